// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: steps fetch/decode/execute one micro-step per
// clock and drives the datapath's bus selects, load enables and strobes.
module control_sequencer #(
  parameter int unsigned RAM_WRITE_STEPS = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        MDRout,
  output logic        InPort_Out,
  output logic        enablePC,
  output logic        enableMAR,
  output logic        enableMDR,
  output logic        enableIR,
  output logic        enableY,
  output logic        enableZ,
  output logic        enableHI,
  output logic        enableLO,
  output logic        IncPC,
  output logic        Read,
  output logic        enableRAM,
  output logic        conIn,
  output logic        enableOutPort,
  output logic        enableInPort,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [15:0] R_ins,
  output logic [4:0]  opcode,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_BR,
    C_JAL, C_JR, C_IN, C_OUT, C_MFLO, C_MFHI, C_NOP, C_HALT
  } op_class_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [1:0] WR_LAST = 2'(RAM_WRITE_STEPS - 1);

  state_t     state_q, state_d;
  logic [1:0] wr_cnt_q, wr_cnt_d;
  op_class_t  cls;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    cls = C_NOP;
    case (op) inside
      5'b00000:            cls = C_LD;
      5'b00001:            cls = C_LDI;
      5'b00010:            cls = C_ST;
      [5'b00011:5'b01011]: cls = C_ALU;
      [5'b01100:5'b01110]: cls = C_IMM;
      5'b01111, 5'b10000:  cls = C_MULDIV;
      5'b10001, 5'b10010:  cls = C_UNARY;
      5'b10011:            cls = C_BR;
      5'b10100:            cls = C_JAL;
      5'b10101:            cls = C_JR;
      5'b10110:            cls = C_IN;
      5'b10111:            cls = C_OUT;
      5'b11000:            cls = C_MFLO;
      5'b11001:            cls = C_MFHI;
      5'b11011:            cls = C_HALT;
      default:             cls = C_NOP;
    endcase
  end

  always_comb begin
    // NOTE: every output and next-state term gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    wr_cnt_d      = '0;
    PCout         = 1'b0;
    Zhighout      = 1'b0;
    Zlowout       = 1'b0;
    HIout         = 1'b0;
    LOout         = 1'b0;
    Cout          = 1'b0;
    MDRout        = 1'b0;
    InPort_Out    = 1'b0;
    enablePC      = 1'b0;
    enableMAR     = 1'b0;
    enableMDR     = 1'b0;
    enableIR      = 1'b0;
    enableY       = 1'b0;
    enableZ       = 1'b0;
    enableHI      = 1'b0;
    enableLO      = 1'b0;
    IncPC         = 1'b0;
    Read          = 1'b0;
    enableRAM     = 1'b0;
    conIn         = 1'b0;
    enableOutPort = 1'b0;
    enableInPort  = 1'b0;
    Gra           = 1'b0;
    Grb           = 1'b0;
    Grc           = 1'b0;
    Rin           = 1'b0;
    Rout          = 1'b0;
    BAout         = 1'b0;
    R_ins         = '0;
    opcode        = '0;
    run           = 1'b0;

    case (state_q)
      S_RESET: state_d = S_T0;

      S_T0: begin
        run       = 1'b1;
        PCout     = 1'b1;
        enableMAR = 1'b1;
        IncPC     = 1'b1;
        state_d   = S_T1;
      end

      S_T1: begin
        run       = 1'b1;
        Read      = 1'b1;
        enableMDR = 1'b1;
        state_d   = S_T2;
      end

      S_T2: begin
        run          = 1'b1;
        MDRout       = 1'b1;
        enableIR     = 1'b1;
        enableInPort = 1'b1;
        case (cls)
          C_HALT:  state_d = S_HALT;
          C_NOP:   state_d = S_T0;
          default: state_d = S_T3;
        endcase
      end

      S_T3: begin
        run     = 1'b1;
        state_d = S_T4;
        case (cls)
          C_LD, C_LDI, C_ST: begin
            Grb = 1'b1; BAout = 1'b1; enableY = 1'b1;
          end
          C_ALU, C_IMM: begin
            Grb = 1'b1; Rout = 1'b1; enableY = 1'b1;
          end
          C_UNARY: begin
            Grb = 1'b1; Rout = 1'b1; opcode = op; enableZ = 1'b1;
          end
          C_MULDIV: begin
            Gra = 1'b1; Rout = 1'b1; enableY = 1'b1;
          end
          C_BR: begin
            Gra = 1'b1; Rout = 1'b1; conIn = 1'b1;
          end
          C_JAL: begin
            PCout = 1'b1; R_ins[15] = 1'b1;
          end
          C_JR: begin
            Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; state_d = S_T0;
          end
          C_MFHI: begin
            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
          end
          C_MFLO: begin
            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
          end
          C_IN: begin
            InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
          end
          C_OUT: begin
            Gra = 1'b1; Rout = 1'b1; enableOutPort = 1'b1; state_d = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end

      S_T4: begin
        run     = 1'b1;
        state_d = S_T5;
        case (cls)
          C_LD, C_LDI, C_ST: begin
            Cout = 1'b1; opcode = OP_ADD; enableZ = 1'b1;
          end
          C_ALU: begin
            Grc = 1'b1; Rout = 1'b1; opcode = op; enableZ = 1'b1;
          end
          C_IMM: begin
            Cout = 1'b1; opcode = op; enableZ = 1'b1;
          end
          C_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; opcode = op; enableZ = 1'b1;
          end
          C_UNARY: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
          end
          C_BR: begin
            PCout = 1'b1; enableY = 1'b1;
          end
          C_JAL: begin
            Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; state_d = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end

      S_T5: begin
        run     = 1'b1;
        state_d = S_T6;
        case (cls)
          C_LD, C_ST: begin
            Zlowout = 1'b1; enableMAR = 1'b1;
          end
          C_LDI, C_ALU, C_IMM: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
          end
          C_MULDIV: begin
            Zlowout = 1'b1; enableLO = 1'b1;
          end
          C_BR: begin
            Cout = 1'b1; opcode = OP_ADD; enableZ = 1'b1;
          end
          default: state_d = S_T0;
        endcase
      end

      S_T6: begin
        run     = 1'b1;
        state_d = S_T0;
        case (cls)
          C_LD: begin
            Read = 1'b1; enableMDR = 1'b1; state_d = S_T7;
          end
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; enableMDR = 1'b1; state_d = S_T7;
          end
          C_MULDIV: begin
            Zhighout = 1'b1; enableHI = 1'b1;
          end
          C_BR: begin
            Zlowout = 1'b1; enablePC = CON;
          end
          default: state_d = S_T0;
        endcase
      end

      S_T7: begin
        run     = 1'b1;
        state_d = S_T0;
        case (cls)
          C_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          C_ST: begin
            // Hold the memory write for RAM_WRITE_STEPS consecutive cycles.
            enableRAM = 1'b1;
            if (wr_cnt_q != WR_LAST) begin
              wr_cnt_d = wr_cnt_q + 2'd1;
              state_d  = S_T7;
            end
          end
          default: state_d = S_T0;
        endcase
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RESET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_RESET;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a step-table model pushes the expected
// per-cycle control word for each issued instruction; a monitor pops and compares.
module tb_control_sequencer;

  localparam int RWS = 2;

  typedef struct packed {
    logic        pc_out, zhigh_out, zlow_out, hi_out, lo_out, c_out, mdr_out, inport_out;
    logic        en_pc, en_mar, en_mdr, en_ir, en_y, en_z, en_hi, en_lo;
    logic        inc_pc, read, en_ram, con_in, en_outport, en_inport;
    logic        gra, grb, grc, rin, rout, ba_out;
    logic [15:0] r_ins;
    logic [4:0]  opcode;
    logic        run;
  } ctrl_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        CON;
  logic PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out;
  logic enablePC, enableMAR, enableMDR, enableIR, enableY, enableZ, enableHI, enableLO;
  logic IncPC, Read, enableRAM, conIn, enableOutPort, enableInPort;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [15:0] R_ins;
  logic [4:0]  opcode;
  logic        run;

  control_sequencer #(.RAM_WRITE_STEPS(RWS)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .MDRout(MDRout), .InPort_Out(InPort_Out),
    .enablePC(enablePC), .enableMAR(enableMAR), .enableMDR(enableMDR),
    .enableIR(enableIR), .enableY(enableY), .enableZ(enableZ),
    .enableHI(enableHI), .enableLO(enableLO), .IncPC(IncPC), .Read(Read),
    .enableRAM(enableRAM), .conIn(conIn), .enableOutPort(enableOutPort),
    .enableInPort(enableInPort), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .R_ins(R_ins), .opcode(opcode), .run(run)
  );

  always #5 clock = ~clock;

  ctrl_t act;
  assign act = {PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out,
                enablePC, enableMAR, enableMDR, enableIR, enableY, enableZ, enableHI, enableLO,
                IncPC, Read, enableRAM, conIn, enableOutPort, enableInPort,
                Gra, Grb, Grc, Rin, Rout, BAout, R_ins, opcode, run};

  ctrl_t exp_q[$];
  string tag_q[$];
  ctrl_t seq_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input ctrl_t got, input ctrl_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (diff %h)", name, got, want, got ^ want);
    end
  endtask

  // Monitor: one expected control word per clock, sampled mid-cycle.
  initial begin
    ctrl_t e;
    string t;
    int    srcs;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, act, e);
        srcs = int'(act.pc_out) + int'(act.zhigh_out) + int'(act.zlow_out) + int'(act.hi_out)
             + int'(act.lo_out) + int'(act.c_out) + int'(act.mdr_out) + int'(act.inport_out)
             + int'(act.rout) + int'(act.ba_out);
        n_checks++;
        if (srcs > 1) begin
          n_errors++;
          $display("FAIL %s bus sources: got %0d drivers, required at most 1", t, srcs);
        end
      end
    end
  end

  function automatic ctrl_t active();
    ctrl_t s = '0;
    s.run = 1'b1;
    return s;
  endfunction

  // Reference model: the control word sequence of one instruction, taken
  // straight from the per-class step lists.
  function automatic void build(input logic [31:0] ir, input logic con);
    logic [4:0] op = ir[31:27];
    ctrl_t s;
    seq_q.delete();
    s = active(); s.pc_out = 1; s.en_mar = 1; s.inc_pc = 1;      seq_q.push_back(s);
    s = active(); s.read = 1; s.en_mdr = 1;                        seq_q.push_back(s);
    s = active(); s.mdr_out = 1; s.en_ir = 1; s.en_inport = 1;    seq_q.push_back(s);
    if (op == 5'd27) begin
      for (int i = 0; i < 20; i++) seq_q.push_back('0);
      return;
    end
    if (op == 5'd26 || op > 5'd27) return;
    if (op <= 5'd2) begin
      s = active(); s.grb = 1; s.ba_out = 1; s.en_y = 1;            seq_q.push_back(s);
      s = active(); s.c_out = 1; s.opcode = 5'd3; s.en_z = 1;       seq_q.push_back(s);
      if (op == 5'd1) begin
        s = active(); s.zlow_out = 1; s.gra = 1; s.rin = 1;         seq_q.push_back(s);
      end else begin
        s = active(); s.zlow_out = 1; s.en_mar = 1;                 seq_q.push_back(s);
        if (op == 5'd0) begin
          s = active(); s.read = 1; s.en_mdr = 1;                   seq_q.push_back(s);
          s = active(); s.mdr_out = 1; s.gra = 1; s.rin = 1;        seq_q.push_back(s);
        end else begin
          s = active(); s.gra = 1; s.rout = 1; s.en_mdr = 1;        seq_q.push_back(s);
          for (int i = 0; i < RWS; i++) begin
            s = active(); s.en_ram = 1;                             seq_q.push_back(s);
          end
        end
      end
    end else if (op <= 5'd14) begin
      s = active(); s.grb = 1; s.rout = 1; s.en_y = 1;              seq_q.push_back(s);
      s = active(); s.opcode = op; s.en_z = 1;
      if (op >= 5'd12) s.c_out = 1; else begin s.grc = 1; s.rout = 1; end
      seq_q.push_back(s);
      s = active(); s.zlow_out = 1; s.gra = 1; s.rin = 1;           seq_q.push_back(s);
    end else if (op == 5'd15 || op == 5'd16) begin
      s = active(); s.gra = 1; s.rout = 1; s.en_y = 1;              seq_q.push_back(s);
      s = active(); s.grb = 1; s.rout = 1; s.opcode = op; s.en_z = 1; seq_q.push_back(s);
      s = active(); s.zlow_out = 1; s.en_lo = 1;                    seq_q.push_back(s);
      s = active(); s.zhigh_out = 1; s.en_hi = 1;                   seq_q.push_back(s);
    end else if (op == 5'd17 || op == 5'd18) begin
      s = active(); s.grb = 1; s.rout = 1; s.opcode = op; s.en_z = 1; seq_q.push_back(s);
      s = active(); s.zlow_out = 1; s.gra = 1; s.rin = 1;           seq_q.push_back(s);
    end else if (op == 5'd19) begin
      s = active(); s.gra = 1; s.rout = 1; s.con_in = 1;            seq_q.push_back(s);
      s = active(); s.pc_out = 1; s.en_y = 1;                       seq_q.push_back(s);
      s = active(); s.c_out = 1; s.opcode = 5'd3; s.en_z = 1;       seq_q.push_back(s);
      s = active(); s.zlow_out = 1; s.en_pc = con;                  seq_q.push_back(s);
    end else if (op == 5'd20) begin
      s = active(); s.pc_out = 1; s.r_ins = 16'h8000;               seq_q.push_back(s);
      s = active(); s.gra = 1; s.rout = 1; s.en_pc = 1;             seq_q.push_back(s);
    end else if (op == 5'd21) begin
      s = active(); s.gra = 1; s.rout = 1; s.en_pc = 1;             seq_q.push_back(s);
    end else if (op == 5'd22) begin
      s = active(); s.inport_out = 1; s.gra = 1; s.rin = 1;         seq_q.push_back(s);
    end else if (op == 5'd23) begin
      s = active(); s.gra = 1; s.rout = 1; s.en_outport = 1;        seq_q.push_back(s);
    end else if (op == 5'd24) begin
      s = active(); s.lo_out = 1; s.gra = 1; s.rin = 1;             seq_q.push_back(s);
    end else begin
      s = active(); s.hi_out = 1; s.gra = 1; s.rin = 1;             seq_q.push_back(s);
    end
  endfunction

  // Called mid-cycle; clear drops asynchronously and is released mid-cycle so
  // the next rising edge enters T0.
  task automatic hold_reset(input int n);
    clear = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('0);
      tag_q.push_back($sformatf("reset cycle %0d", i));
    end
    repeat (n) @(negedge clock);
    #1;
    clear = 1'b1;
  endtask

  // Issues one instruction (or its first 'steps' cycles when steps > 0).
  task automatic issue(input logic [31:0] ir, input logic con, input string name,
                       input int steps);
    int n;
    build(ir, con);
    n = (steps <= 0 || steps > seq_q.size()) ? seq_q.size() : steps;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(seq_q[i]);
      tag_q.push_back($sformatf("%s ir=%h con=%0b step %0d", name, ir, con, i));
    end
    @(posedge clock);
    #1;
    IR  = ir;
    CON = con;
    repeat (n) @(negedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [26:0] rest = 27'($urandom);
    return {op, rest};
  endfunction

  initial begin
    logic [4:0]  op;
    logic [31:0] ir;
    logic        c;
    clear = 1'b0;
    IR    = '0;
    CON   = 1'b0;
    hold_reset(2);

    issue(32'h1891_8000, 1'b0, "add aborted", 5);
    hold_reset(3);

    issue(32'h0100_0095, 1'b0, "ld", 0);
    issue(32'h61A7_FFFB, 1'b0, "addi", 0);
    issue(32'h9A80_000E, 1'b1, "brzr taken", 0);
    issue(32'h9A80_000E, 1'b0, "brzr not taken", 0);
    issue(32'h81A0_0000, 1'b0, "mul", 0);
    issue(32'hA300_0000, 1'b0, "jal", 0);
    issue(mk(5'd2), 1'b0, "st", 0);
    issue(mk(5'd1), 1'b0, "ldi", 0);
    issue(mk(5'd11), 1'b0, "shl", 0);
    issue(mk(5'd14), 1'b0, "ori", 0);
    issue(mk(5'd15), 1'b1, "div", 0);
    issue(mk(5'd17), 1'b0, "neg", 0);
    issue(mk(5'd18), 1'b0, "not", 0);
    issue(mk(5'd21), 1'b0, "jr", 0);
    issue(mk(5'd22), 1'b0, "in", 0);
    issue(mk(5'd23), 1'b0, "out", 0);
    issue(mk(5'd24), 1'b0, "mflo", 0);
    issue(mk(5'd25), 1'b0, "mfhi", 0);
    issue(mk(5'd26), 1'b0, "nop", 0);
    issue(mk(5'd29), 1'b0, "undefined", 0);
    issue(mk(5'd2), 1'b0, "st aborted", 8);
    hold_reset(1);

    for (int i = 0; i < 120; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      ir = mk(op);
      c  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        issue(ir, c, "random aborted", int'($urandom_range(1, 9)));
        hold_reset(int'($urandom_range(1, 3)));
      end else begin
        issue(ir, c, "random", 0);
      end
    end

    issue(32'hD800_0000, 1'b0, "halt", 0);
    hold_reset(1);
    issue(mk(5'd1), 1'b0, "ldi after halt", 0);
    issue(mk(5'd3), 1'b1, "add after halt", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Phase-2 datapath's control inputs.
- Sequences fetch, decode and execute for the Mini SRC instruction set: one micro-step per clock.
- The datapath responds to the control strobes; this block initiates them, using IR contents and the CON flag fed back from the datapath.
- It is the top-level partner of the datapath in the Phase-3 CPU.

Parameters:
RAM_WRITE_STEPS, 1, cycles enableRAM is held during a store write step (1..3)

Ports:
clock  in  1  system clock, all state changes on rising edge
clear  in  1  asynchronous reset, active-low
IR  in  32  instruction register contents from datapath
CON  in  1  branch condition flag from CON FF
PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out  out  1 each  bus source selects
enablePC, enableMAR, enableMDR, enableIR, enableY, enableZ, enableHI, enableLO  out  1 each  register load enables
IncPC, Read, enableRAM, conIn, enableOutPort, enableInPort  out  1 each  misc strobes (enableRAM = memory write)
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select/encode controls
R_ins  out  16  direct GPR load enables (only bit 15 used, for jal)
opcode  out  5  ALU operation
run  out  1  high while executing, low when halted or in reset

Behaviour:
- Decode: op = IR[31:27]. ld 00000, ldi 00001, st 00010, add..shl 00011–01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jal 10100, jr 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011. Undefined opcodes execute as nop.
- States: RESET, T0..T7, HALT. Outputs are Moore, decoded from state and IR; all are 0 unless listed.
- clear low (any time, mid-instruction included): state RESET, all outputs 0, run 0. The instruction in progress is abandoned. First rising edge with clear high: RESET→T0. run is 1 in T0..T7.
- Fetch:
  - T0: PCout, enableMAR, IncPC.
  - T1: Read, enableMDR.
  - T2: MDRout, enableIR, enableInPort.
  - Execute begins at T3 using the newly latched IR.
- Every class returns to T0 after its last step.
- ld: T3 Grb,BAout,enableY; T4 Cout,opcode=00011,enableZ; T5 Zlowout,enableMAR; T6 Read,enableMDR; T7 MDRout,Gra,Rin.
- ldi: T3, T4 as ld; T5 Zlowout,Gra,Rin.
- st: T3–T5 as ld; T6 Gra,Rout,enableMDR (Read=0); T7 enableRAM for RAM_WRITE_STEPS cycles.
- Register ALU (00011–01011): T3 Grb,Rout,enableY; T4 Grc,Rout,opcode=op,enableZ; T5 Zlowout,Gra,Rin.
- Immediate ALU (addi/andi/ori): as register ALU, but T4 uses Cout instead of Grc,Rout.
- neg/not: T3 Grb,Rout,opcode=op,enableZ; T4 Zlowout,Gra,Rin.
- mul/div: T3 Gra,Rout,enableY; T4 Grb,Rout,opcode=op,enableZ; T5 Zlowout,enableLO; T6 Zhighout,enableHI.
- br: T3 Gra,Rout,conIn; T4 PCout,enableY; T5 Cout,opcode=00011,enableZ; T6 Zlowout, enablePC only if CON=1.
- jr: T3 Gra,Rout,enablePC.
- jal: T3 PCout,R_ins[15]; T4 Gra,Rout,enablePC.
- mfhi/mflo: T3 HIout/LOout,Gra,Rin.
- in: T3 InPort_Out,Gra,Rin.
- out: T3 Gra,Rout,enableOutPort.
- nop: T2→T0.
- halt: T2→HALT. In HALT all outputs are 0 and run is 0; the block remains there until clear.
- opcode output holds 00000 whenever enableZ is 0.
- At most one bus-source select is high in any cycle. No enable is asserted in the same cycle as clear low.

Test Plan:
- Reset: hold clear=0 for 3 cycles mid-T4 of an add, then release → all outputs 0 and run=0 while low; T0 asserted on the first edge after release (PCout=enableMAR=IncPC=1).
- ld R2,0x95 (IR=0x01000095) → T3–T7 match the ld list; Gra&Rin in T7; back in T0 at instruction cycle 9.
- addi R3,R4,-5 (IR=0x61A7FFFB) → T4 has Cout=1, opcode=01100, enableZ=1; T5 Zlowout,Gra,Rin; instruction takes 6 cycles.
- brzr R5,14 (IR=0x9A80000E):
  - CON=1 → enablePC=1 in T6.
  - CON=0 → enablePC=0 in T6.
  - Both cases return to T0 after T6.
- mul R3,R4 (IR=0x81A00000) → enableLO in T5, enableHI in T6, 7 cycles total. jal R6 (IR=0xA3000000) → R_ins=0x8000 with PCout in T3; enablePC with Gra,Rout in T4.
- halt (IR=0xD8000000) → run falls after T2 and stays 0 for 20 cycles with all outputs 0; clear pulse → fetch restarts.
